// File: rtl/sc_pkg.sv
// Shared types and constants for the stochastic-stream decoder.
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } sc_state_e;

    localparam int unsigned DEF_LEN_W = 8;
    localparam int unsigned DEF_WIN   = 1 << DEF_LEN_W;

endpackage

// File: rtl/sc_ones_counter.sv
// Ones accumulator: wide enough to reach the full window without wrapping.
module sc_ones_counter
    import sc_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_LEN_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + CNT_W'(bit_in);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/sc_stream_decoder.sv
// Converts a single-bit stochastic stream back to binary by counting ones
// over a fixed window of valid samples; result offered on valid/ready.
module sc_stream_decoder
    import sc_pkg::*;
#(
    parameter int unsigned LEN_W = DEF_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LEN_W-1:0] result,
    output logic             sat
);

    localparam int unsigned CNT_W = LEN_W + 1;
    localparam logic [CNT_W-1:0] WIN_C = {1'b1, {LEN_W{1'b0}}};

    sc_state_e        state_q, state_d;
    logic [LEN_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [LEN_W-1:0] result_q, result_d;
    logic             sat_q, sat_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;

    logic             ones_clr;
    logic             ones_en;
    logic [CNT_W-1:0] ones_cnt;
    logic [CNT_W-1:0] final_cnt;

    sc_ones_counter #(
        .CNT_W (CNT_W)
    ) u_ones (
        .clk    (clk),
        .rst    (rst),
        .clr    (ones_clr),
        .en     (ones_en),
        .bit_in (bit_in),
        .count  (ones_cnt)
    );

    // Count including the sample presented this cycle, used on the terminal sample.
    assign final_cnt = ones_cnt + CNT_W'(bit_in);

    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        result_d   = result_q;
        sat_d      = sat_q;
        ones_clr   = 1'b0;
        ones_en    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = COUNT;
                    samp_cnt_d = '0;
                    ones_clr   = 1'b1;
                end
            end
            COUNT: begin
                // Abort wins over a coincident terminal sample.
                if (abort) begin
                    state_d = IDLE;
                end else if (bit_valid) begin
                    ones_en    = 1'b1;
                    samp_cnt_d = samp_cnt_q + LEN_W'(1);
                    if (samp_cnt_q == {LEN_W{1'b1}}) begin
                        state_d = HOLD;
                        sat_d   = (final_cnt == WIN_C);
                        if (final_cnt == WIN_C) begin
                            result_d = {LEN_W{1'b1}};
                        end else begin
                            result_d = final_cnt[LEN_W-1:0];
                        end
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d      = (state_d == COUNT);
        out_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            samp_cnt_q  <= '0;
            result_q    <= '0;
            sat_q       <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_cnt_q  <= samp_cnt_d;
            result_q    <= result_d;
            sat_q       <= sat_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Randomised scoreboard bench for sc_stream_decoder (window = 256 samples).
module tb_sc_stream_decoder;

    localparam int unsigned LEN_W = 8;
    localparam int WIN = 256;

    typedef struct {
        int res;
        int sat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic             bit_valid;
    logic             bit_in;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [LEN_W-1:0] result;
    logic             sat;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cc     = 0;
    int   last_res = 0;
    int   last_sat = 0;
    exp_t exp_q[$];
    bit   win_bits[WIN];

    sc_stream_decoder #(.LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sat       (sat)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // One clock cycle of stimulus; outputs are stable when this returns.
    task automatic cyc(input logic s, input logic ab, input logic bv, input logic bi);
        start     = s;
        abort     = ab;
        bit_valid = bv;
        bit_in    = bi;
        @(posedge clk);
        #1;
    endtask

    // Drives one valid sample, preceded by stall cycles per mode
    // (0: none, 1: every third cycle, 2: random bursts). Stalls also wiggle start.
    task automatic send_sample(input bit b, input int mode, input logic ab);
        if (mode == 1 && (cc % 3) == 2) begin
            cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            cc++;
        end else if (mode == 2) begin
            int n = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            for (int k = 0; k < n; k++)
                cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        cyc(1'b0, ab, 1'b1, b);
        cc++;
    endtask

    // Start cycle carries a 1 sample, which must not be counted.
    task automatic do_start(input string tag);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        check({tag, "_busy_after_start"}, int'(busy), 1);
    endtask

    task automatic run_window(input int mode, input string tag);
        int ones = 0;
        exp_t e;
        cc = 0;
        do_start(tag);
        for (int i = 0; i < WIN - 1; i++) send_sample(win_bits[i], mode, 1'b0);
        check({tag, "_busy_pre_term"}, int'(busy), 1);
        check({tag, "_valid_pre_term"}, int'(out_valid), 0);
        foreach (win_bits[i]) ones += int'(win_bits[i]);
        e.res = (ones > WIN - 1) ? WIN - 1 : ones;
        e.sat = (ones == WIN) ? 1 : 0;
        exp_q.push_back(e);
        last_res = e.res;
        last_sat = e.sat;
        send_sample(win_bits[WIN-1], mode, 1'b0);
        check({tag, "_valid_latency"}, int'(out_valid), 1);
        check({tag, "_busy_in_hold"}, int'(busy), 0);
        if (out_ready) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
            check({tag, "_valid_after_accept"}, int'(out_valid), 0);
            check({tag, "_busy_after_accept"}, int'(busy), 0);
        end
    endtask

    // Scoreboard monitor: every cycle a result is offered, it must match the queue head.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                check("mon_result", int'(result), exp_q[0].res);
                check("mon_sat", int'(sat), exp_q[0].sat);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_sat", int'(sat), 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("idle_abort_ignored", int'(busy), 0);

        foreach (win_bits[i]) win_bits[i] = 1'b0;
        run_window(0, "zeros");

        foreach (win_bits[i]) win_bits[i] = ((i % 2) == 0);
        run_window(1, "half");

        foreach (win_bits[i]) win_bits[i] = 1'b1;
        run_window(0, "ones");
        check("ones_sat_direct", int'(sat), 1);

        foreach (win_bits[i]) win_bits[i] = (i != WIN - 1);
        run_window(0, "ones255");
        check("ones255_sat_direct", int'(sat), 0);

        // Backpressure with start pulses in HOLD and on the accepting cycle.
        foreach (win_bits[i]) win_bits[i] = 1'($urandom_range(0, 1));
        out_ready = 1'b0;
        run_window(2, "bp");
        for (int k = 0; k < 10; k++) begin
            cyc(1'(k == 3 || k == 7), 1'b1, 1'b1, 1'($urandom_range(0, 1)));
            check("bp_valid_held", int'(out_valid), 1);
            check("bp_busy_low", int'(busy), 0);
        end
        out_ready = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        check("bp_valid_after_accept", int'(out_valid), 0);
        check("bp_busy_after_accept", int'(busy), 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("bp_start_on_accept_ignored", int'(busy), 0);
        check("bp_result_kept", int'(result), last_res);

        // Abort after 100 samples.
        cc = 0;
        do_start("abort");
        for (int i = 0; i < 100; i++) send_sample(1'b1, 2, 1'b0);
        send_sample(1'b1, 0, 1'b1);
        check("abort_busy", int'(busy), 0);
        check("abort_valid", int'(out_valid), 0);
        check("abort_result_kept", int'(result), last_res);
        check("abort_sat_kept", int'(sat), last_sat);
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("abort_stays_idle", int'(busy), 0);
        foreach (win_bits[i]) win_bits[i] = (i < 64);
        run_window(1, "post_abort");

        // Synchronous reset mid-window.
        cc = 0;
        do_start("rstmid");
        for (int i = 0; i < 50; i++) send_sample(1'b1, 0, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        last_res = 0;
        last_sat = 0;
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_valid", int'(out_valid), 0);
        check("rstmid_result", int'(result), 0);
        check("rstmid_sat", int'(sat), 0);
        foreach (win_bits[i]) win_bits[i] = ($urandom_range(0, 3) != 0);
        run_window(2, "post_rst");

        // Abort coincident with the terminal sample.
        cc = 0;
        do_start("race");
        for (int i = 0; i < WIN - 1; i++) send_sample(1'b1, 0, 1'b0);
        send_sample(1'b1, 0, 1'b1);
        check("race_busy", int'(busy), 0);
        check("race_valid", int'(out_valid), 0);
        check("race_result_kept", int'(result), last_res);
        check("race_sat_kept", int'(sat), last_sat);
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("race_no_late_valid", int'(out_valid), 0);

        for (int w = 0; w < 3; w++) begin
            int dens = $urandom_range(0, 4);
            foreach (win_bits[i]) win_bits[i] = ($urandom_range(0, 3) < dens);
            run_window(2, "rand");
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Downstream stage of the stochastic-computing circuit block: consumes the single-bit stochastic output stream (output_circuit) and converts it back to binary.
- Counts ones over a fixed window of 2^LEN_W valid samples and presents the count as a binary probability estimate.
- Returns the result on a valid/ready handshake to the result collector.
- Sits between the SC circuit/LFSR loop and the result capture logic; one decode per start request.

Parameters:
- LEN_W, 8, log2 of stream length; window = 2^LEN_W samples (default 256).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  request a new decode window; honoured only in IDLE
- abort  in  1  cancel the window in progress; honoured only in COUNT
- bit_valid  in  1  bit_in carries a stream sample this cycle
- bit_in  in  1  stochastic stream sample (from output_circuit)
- busy  out  1  high in COUNT
- out_valid  out  1  result available (HOLD)
- out_ready  in  1  consumer accepts result
- result  out  LEN_W  ones count, saturated
- sat  out  1  window was all ones (true count 2^LEN_W)

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE. busy=0, out_valid=0, result=0, sat=0. Internal sample and ones counters are cleared. Reset overrides every other input, including mid-window and in HOLD.
- Counters: samp_cnt is LEN_W bits. ones_cnt is LEN_W+1 bits, so it holds 0..2^LEN_W without wrap.
- IDLE:
  - start=1 → COUNT next cycle; samp_cnt=0, ones_cnt=0.
  - Samples presented in IDLE are ignored, including the start cycle itself.
  - abort is ignored.
- COUNT:
  - Each cycle with bit_valid=1: ones_cnt += bit_in; samp_cnt += 1.
  - bit_valid=0 cycles are stall cycles; no counter changes.
  - Terminal sample: bit_valid=1 with samp_cnt=2^LEN_W-1. That sample is included, then the block goes to HOLD next cycle.
  - On entry to HOLD:
    - result = min(final ones_cnt, 2^LEN_W-1).
    - sat = (final ones_cnt == 2^LEN_W).
    - Latency: out_valid rises the cycle after the terminal sample.
  - abort=1 → IDLE next cycle. The current sample is discarded. result and sat keep their previous values; out_valid stays 0.
  - abort has priority over a coincident terminal sample.
  - start in COUNT is ignored.
- HOLD:
  - out_valid=1. result and sat stay stable until the handshake completes.
  - out_valid && out_ready → IDLE next cycle, out_valid=0. result and sat keep their values until the next HOLD entry.
  - start is ignored while in HOLD. A start coincident with the accepting cycle is also ignored; a new window needs start again in IDLE.
  - bit_in and abort are ignored.
- busy = (state==COUNT), registered with state.
- The window is exactly 2^LEN_W valid samples regardless of stall pattern.

Decomposition:
- Package sc_pkg:
  - state enum {IDLE, COUNT, HOLD}.
  - Default LEN_W constant.
  - Helper constant WIN = 1 << LEN_W.
- One natural sub-module: sc_ones_counter, a saturation-free LEN_W+1 bit accumulator with clear and enable.
- FSM and output registers stay in sc_stream_decoder.

Test Plan:
- All-zero stream: start, 256 samples with bit_valid=1, bit_in=0 → out_valid one cycle after the 256th sample; result=0, sat=0, busy low from that cycle.
- Half-density stream: 256 samples alternating 1/0, with bit_valid=0 inserted every 3rd cycle → result=128, sat=0. The out_valid cycle is set by valid-sample count, not wall-clock cycles.
- All-ones stream, 256 samples of 1 → result=255 (saturated), sat=1. Follow with 255 ones and one 0 → result=255, sat=0.
- Backpressure and start in HOLD:
  - Hold out_ready=0 for 10 cycles after out_valid; pulse start during HOLD.
  - Required: result stable, start ignored.
  - out_ready=1 → IDLE next cycle, out_valid=0, busy stays 0.
- Abort and reset:
  - abort after 100 samples → IDLE, out_valid never rises; the next full window of 64 ones then 192 zeros → result=64.
  - rst=1 mid-window at sample 50 → all outputs 0 next cycle; later start counts from 0.
- Terminal-sample race: abort coincident with the 256th valid sample → IDLE, no out_valid, previous result retained.
